// File: rtl/grf_sb.sv
// grf_sb: general register file, two write ports, NRD read ports,
// write-through bypass and per-register pending-write scoreboard.
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD*ADDR_W-1:0]    ra,
  output logic [NRD*DATA_W-1:0]    rd,
  output logic [NRD-1:0]           rbusy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [31:0]              pc0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [31:0]              pc1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_a,
  output logic                     iss_rdy,
  output logic                     err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = PEND_W + 1;
  localparam logic [PEND_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [PEND_W-1:0] cnt   [DEPTH];
  logic [PEND_W-1:0] cnt_n [DEPTH];
  logic [DEPTH-1:0]  over;

  logic e0;
  logic e1;
  logic same;
  logic is0;
  logic is1;

  // The PCs only annotate the writeback trace and carry no datapath meaning.
  logic unused_pc;
  assign unused_pc = ^{pc0, pc1};

  // A write is effective only when enabled and not aimed at $0.
  assign e0   = we0 && (wa0 != '0);
  assign e1   = we1 && (wa1 != '0);
  assign same = e0 && e1 && (wa0 == wa1);

  // A saturated destination is still issuable when a writer retires it now.
  assign is0     = e0 && (wa0 == iss_a);
  assign is1     = e1 && (wa1 == iss_a);
  assign iss_rdy = !((cnt[iss_a] == CMAX) && !is0 && !is1);

  // Read ports: W1 bypass beats W0 bypass beats the array.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              h0;
    logic              h1;
    logic [CW-1:0]     nw;
    assign a  = ra[g*ADDR_W +: ADDR_W];
    assign h0 = e0 && (wa0 == a);
    assign h1 = e1 && (wa1 == a);
    assign nw = CW'(h0) + CW'(h1);
    assign rd[g*DATA_W +: DATA_W] =
      (a == '0) ? '0 :
      h1        ? wd1 :
      h0        ? wd0 : mem[a];
    assign rbusy[g] = (a != '0) && (CW'(cnt[a]) > nw);
  end

  assign cnt_n[0] = '0;
  assign over[0]  = 1'b0;

  // Per-register count update: +issue, -retires floored at zero.
  for (genvar r = 1; r < DEPTH; r++) begin : g_sb
    logic          h0;
    logic          h1;
    logic          inc;
    logic [CW-1:0] n;
    logic [CW-1:0] c;
    logic [CW-1:0] dec;
    assign h0  = e0 && (wa0 == ADDR_W'(r));
    assign h1  = e1 && (wa1 == ADDR_W'(r));
    assign inc = iss_en && iss_rdy && (iss_a == ADDR_W'(r));
    assign n   = CW'(h0) + CW'(h1);
    assign c   = CW'(cnt[r]);
    assign dec = (n > c) ? c : n;
    assign over[r]  = n > c;
    assign cnt_n[r] = PEND_W'(c + CW'(inc) - dec);
  end

  // Array, counters and sticky error; reset drops same-cycle traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      if (e0 && !same) mem[wa0] <= wd0;
      if (e1)          mem[wa1] <= wd1;
      for (int r = 0; r < DEPTH; r++) begin
        cnt[r] <= cnt_n[r];
      end
      if (|over) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed scoreboard bench for grf_sb.
// Expected values are queued when stimulus is applied, popped on sample.
module tb_grf_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1, pc0, pc1;
  logic        iss_en;
  logic [4:0]  iss_a;
  logic        iss_rdy;
  logic        err;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  grf_sb #(
    .DATA_W(32), .ADDR_W(5), .NRD(2), .PEND_W(2)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
    .iss_en(iss_en), .iss_a(iss_a), .iss_rdy(iss_rdy), .err(err)
  );

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    ncmp++;
    if (exp_q.size() == 0) begin
      nfail++;
      $display("FAIL sb_empty: observed %h required nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        nfail++;
        $error("FAIL %s: observed %h required %h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0; pc0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; pc1 = '0;
    iss_en = 1'b0; iss_a = '0;
  endtask

  task automatic go(input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    idle();
    ra = {a1, a0};
  endtask

  task automatic issue(input logic [4:0] a);
    go(5'd0, 5'd0);
    iss_en = 1'b1;
    iss_a  = a;
    #1;
    push("iss_ok", 32'd1);
    pop_cmp({31'b0, iss_rdy});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    ra = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    go(5'd5, 5'd0); #1;
    push("rst_rd0", 32'd0);   pop_cmp(rd[31:0]);
    push("rst_busy", 32'd0);  pop_cmp({30'b0, rbusy});
    push("rst_rdy", 32'd1);   pop_cmp({31'b0, iss_rdy});
    push("rst_err", 32'd0);   pop_cmp({31'b0, err});

    issue(5'd5);
    go(5'd5, 5'd0); #1;
    push("pend5_busy", 32'd1); pop_cmp({31'b0, rbusy[0]});

    go(5'd5, 5'd0);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234_5678; pc0 = 32'h100;
    #1;
    push("byp5_rd0", 32'h1234_5678); pop_cmp(rd[31:0]);
    push("byp5_rd1", 32'd0);         pop_cmp(rd[63:32]);
    push("byp5_busy", 32'd0);        pop_cmp({30'b0, rbusy});

    go(5'd5, 5'd0); #1;
    push("arr5_rd0", 32'h1234_5678); pop_cmp(rd[31:0]);
    push("arr5_err", 32'd0);         pop_cmp({31'b0, err});

    go(5'd0, 5'd0);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_a = 5'd0;
    #1;
    push("r0_rd0", 32'd0);  pop_cmp(rd[31:0]);
    push("r0_rd1", 32'd0);  pop_cmp(rd[63:32]);
    push("r0_busy", 32'd0); pop_cmp({30'b0, rbusy});
    push("r0_rdy", 32'd1);  pop_cmp({31'b0, iss_rdy});

    go(5'd0, 5'd0); #1;
    push("r0_after", 32'd0); pop_cmp(rd[31:0]);
    push("r0_busy2", 32'd0); pop_cmp({30'b0, rbusy});
    push("r0_err", 32'd0);   pop_cmp({31'b0, err});

    issue(5'd7);
    issue(5'd7);
    go(5'd7, 5'd0);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA; pc0 = 32'h200;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hB; pc1 = 32'h204;
    #1;
    push("dual7_rd", 32'hB);  pop_cmp(rd[31:0]);
    push("dual7_busy", 32'd0); pop_cmp({31'b0, rbusy[0]});

    go(5'd7, 5'd0); #1;
    push("arr7_rd", 32'hB);  pop_cmp(rd[31:0]);
    push("arr7_busy", 32'd0); pop_cmp({31'b0, rbusy[0]});
    push("dual7_err", 32'd0); pop_cmp({31'b0, err});

    for (int k = 0; k < 3; k++) issue(5'd3);

    go(5'd0, 5'd3);
    iss_en = 1'b1; iss_a = 5'd3;
    #1;
    push("sat3_rdy", 32'd0);  pop_cmp({31'b0, iss_rdy});
    push("sat3_busy", 32'd1); pop_cmp({31'b0, rbusy[1]});

    go(5'd0, 5'd3);
    iss_en = 1'b1; iss_a = 5'd3;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h30;
    #1;
    push("satret_rdy", 32'd1);  pop_cmp({31'b0, iss_rdy});
    push("satret_busy", 32'd1); pop_cmp({31'b0, rbusy[1]});
    push("satret_rd", 32'h30);  pop_cmp(rd[63:32]);

    for (int k = 1; k <= 3; k++) begin
      go(5'd0, 5'd3);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h30 + k;
      #1;
      push("ret3_busy", (k < 3) ? 32'd1 : 32'd0);
      pop_cmp({31'b0, rbusy[1]});
      push("ret3_rd", 32'h30 + k);
      pop_cmp(rd[63:32]);
    end

    go(5'd0, 5'd3);
    iss_a = 5'd3;
    #1;
    push("done3_rd", 32'h33);  pop_cmp(rd[63:32]);
    push("done3_busy", 32'd0); pop_cmp({31'b0, rbusy[1]});
    push("done3_rdy", 32'd1);  pop_cmp({31'b0, iss_rdy});
    push("done3_err", 32'd0);  pop_cmp({31'b0, err});

    go(5'd9, 5'd0);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9999;
    #1;
    push("nopend_err0", 32'd0); pop_cmp({31'b0, err});

    go(5'd9, 5'd0);
    iss_en = 1'b1; iss_a = 5'd10;
    #1;
    push("nopend_err", 32'd1);   pop_cmp({31'b0, err});
    push("nopend_rd", 32'h9999); pop_cmp(rd[31:0]);

    repeat (3) go(5'd9, 5'd10);
    #1;
    push("err_sticky", 32'd1);  pop_cmp({31'b0, err});
    push("pend10_busy", 32'd1); pop_cmp({31'b0, rbusy[1]});

    go(5'd9, 5'd10);
    reset = 1'b1;
    go(5'd9, 5'd10); #1;
    push("rst2_err", 32'd0);  pop_cmp({31'b0, err});
    push("rst2_rd0", 32'd0);  pop_cmp(rd[31:0]);
    push("rst2_rd1", 32'd0);  pop_cmp(rd[63:32]);
    push("rst2_busy", 32'd0); pop_cmp({30'b0, rbusy});

    issue(5'd4);
    go(5'd4, 5'd0);
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44;
    go(5'd4, 5'd0); #1;
    push("rstwr_rd", 32'd0);   pop_cmp(rd[31:0]);
    push("rstwr_busy", 32'd0); pop_cmp({31'b0, rbusy[0]});
    push("rstwr_err", 32'd0);  pop_cmp({31'b0, err});

    issue(5'd12);
    go(5'd12, 5'd0);
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h2;
    #1;
    push("ovr_rd", 32'h2);   pop_cmp(rd[31:0]);
    push("ovr_busy", 32'd0); pop_cmp({31'b0, rbusy[0]});

    go(5'd12, 5'd0); #1;
    push("ovr_err", 32'd1);  pop_cmp({31'b0, err});
    push("ovr_arr", 32'h2);  pop_cmp(rd[31:0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
